// File: rtl/score_counter_mux.sv
`default_nettype none
// ============================================================================
// Module      : score_counter_mux
// Description : Scoreboard core. Five raw push-buttons, each with a 2-FF
//               synchroniser, debouncer and rising-edge detector, drive two
//               BCD team scores (00..99) shown on four multiplexed 7-segment
//               digits.
//               Build option SCORE_SAT_EN: when defined, scores saturate at
//               00/99; when undefined, scores wrap 99->00 and 00->99.
// Revision    : 1.0 - initial release
// ============================================================================
module score_counter_mux #(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int REFRESH_DIV     = 10000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_a_inc,
    input  logic       btn_a_dec,
    input  logic       btn_b_inc,
    input  logic       btn_b_dec,
    input  logic       btn_clr,
    output logic [7:0] score_a,
    output logic [7:0] score_b,
    output logic [6:0] seg,
    output logic       dp,
    output logic [1:0] digit_sel
);

    localparam int c_NUM_BTN = 5;
    localparam int c_DEB_W   = $clog2(DEBOUNCE_CYCLES);
    localparam int c_REF_W   = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [c_DEB_W-1:0] c_DEB_LAST = c_DEB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [c_REF_W-1:0] c_REF_LAST = c_REF_W'(REFRESH_DIV - 1);

    // Bit positions in the button vectors
    localparam int c_BTN_A_INC = 0;
    localparam int c_BTN_A_DEC = 1;
    localparam int c_BTN_B_INC = 2;
    localparam int c_BTN_B_DEC = 3;
    localparam int c_BTN_CLR   = 4;

    logic [c_NUM_BTN-1:0] w_raw;
    logic [c_NUM_BTN-1:0] w_pulse;

    assign w_raw = {btn_clr, btn_b_dec, btn_b_inc, btn_a_dec, btn_a_inc};

    generate
        for (genvar gi = 0; gi < c_NUM_BTN; gi++) begin : g_btn
            logic               r_sync1;
            logic               r_sync2;
            logic               r_deb;
            logic               r_deb_q;
            logic [c_DEB_W-1:0] r_cnt;

            // Two-flop synchroniser for the asynchronous button input
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_sync1 <= 1'b0;
                    r_sync2 <= 1'b0;
                end else begin
                    r_sync1 <= w_raw[gi];
                    r_sync2 <= r_sync1;
                end
            end

            // Debouncer: level flips only after the synchronised input has
            // disagreed with it for DEBOUNCE_CYCLES consecutive cycles
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_cnt <= '0;
                    r_deb <= 1'b0;
                end else if (r_sync2 == r_deb) begin
                    r_cnt <= '0;
                end else if (r_cnt == c_DEB_LAST) begin
                    r_deb <= r_sync2;
                    r_cnt <= '0;
                end else begin
                    r_cnt <= r_cnt + c_DEB_W'(1);
                end
            end

            // Delayed debounced level for press-edge detection
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_deb_q <= 1'b0;
                end else begin
                    r_deb_q <= r_deb;
                end
            end

            assign w_pulse[gi] = r_deb & ~r_deb_q;
        end
    endgenerate

    // BCD +1 with ones carry; boundary behaviour chosen at build time
    function automatic logic [7:0] f_bcd_inc(input logic [7:0] v);
        if (v == 8'h99) begin
`ifdef SCORE_SAT_EN
            f_bcd_inc = 8'h99;
`else
            f_bcd_inc = 8'h00;
`endif
        end else if (v[3:0] == 4'd9) begin
            f_bcd_inc = {v[7:4] + 4'd1, 4'd0};
        end else begin
            f_bcd_inc = {v[7:4], v[3:0] + 4'd1};
        end
    endfunction

    // BCD -1 with ones borrow; boundary behaviour chosen at build time
    function automatic logic [7:0] f_bcd_dec(input logic [7:0] v);
        if (v == 8'h00) begin
`ifdef SCORE_SAT_EN
            f_bcd_dec = 8'h00;
`else
            f_bcd_dec = 8'h99;
`endif
        end else if (v[3:0] == 4'd0) begin
            f_bcd_dec = {v[7:4] - 4'd1, 4'd9};
        end else begin
            f_bcd_dec = {v[7:4], v[3:0] - 4'd1};
        end
    endfunction

    // Simultaneous inc and dec of one team cancel out
    function automatic logic [7:0] f_next(input logic [7:0] v, input logic inc, input logic dec);
        if (inc && dec) begin
            f_next = v;
        end else if (inc) begin
            f_next = f_bcd_inc(v);
        end else if (dec) begin
            f_next = f_bcd_dec(v);
        end else begin
            f_next = v;
        end
    endfunction

    logic [7:0] r_score_a;
    logic [7:0] r_score_b;

    // Score registers; clear has priority and swallows same-cycle pulses
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_score_a <= 8'h00;
            r_score_b <= 8'h00;
        end else if (w_pulse[c_BTN_CLR]) begin
            r_score_a <= 8'h00;
            r_score_b <= 8'h00;
        end else begin
            r_score_a <= f_next(r_score_a, w_pulse[c_BTN_A_INC], w_pulse[c_BTN_A_DEC]);
            r_score_b <= f_next(r_score_b, w_pulse[c_BTN_B_INC], w_pulse[c_BTN_B_DEC]);
        end
    end

    logic [c_REF_W-1:0] r_refresh;
    logic [1:0]         r_digit_sel;

    // Refresh divider; each terminal count advances to the next digit
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_refresh   <= '0;
            r_digit_sel <= 2'd0;
        end else if (r_refresh == c_REF_LAST) begin
            r_refresh   <= '0;
            r_digit_sel <= r_digit_sel + 2'd1;
        end else begin
            r_refresh   <= r_refresh + c_REF_W'(1);
        end
    end

    logic [3:0] w_nibble;

    // Select the nibble for the active digit and decode it to segments
    always_comb begin
        w_nibble = 4'd0;
        seg      = 7'h00;
        case (r_digit_sel)
            2'd0:    w_nibble = r_score_a[7:4];
            2'd1:    w_nibble = r_score_a[3:0];
            2'd2:    w_nibble = r_score_b[7:4];
            default: w_nibble = r_score_b[3:0];
        endcase
        case (w_nibble)
            4'd0:    seg = 7'h3F;
            4'd1:    seg = 7'h06;
            4'd2:    seg = 7'h5B;
            4'd3:    seg = 7'h4F;
            4'd4:    seg = 7'h66;
            4'd5:    seg = 7'h6D;
            4'd6:    seg = 7'h7D;
            4'd7:    seg = 7'h07;
            4'd8:    seg = 7'h7F;
            4'd9:    seg = 7'h6F;
            default: seg = 7'h00;
        endcase
    end

    assign dp        = (r_digit_sel == 2'd1);
    assign digit_sel = r_digit_sel;
    assign score_a   = r_score_a;
    assign score_b   = r_score_b;

endmodule
`default_nettype wire
